uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter among `NUM_REQ` independent byte producers (e.g. loopback path, status reporter, debug dump). Round-robin arbitration is done one byte at a time. The block drives the transmitter's one-cycle request/byte interface and tracks its `busy` flag, so each byte is handed over exactly once. The block sits between the producers and the transmitter, alongside the shared baud pulse generator. It has no knowledge of baud timing.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: clock cycles allowed for `tx_busy` to rise after `tx_req`. Range 2..255.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  level request per requester. Held high, with its byte stable, until the matching `ack`.
- `byte_in`  in  8*NUM_REQ  requester i's byte is on bits [8i+7:8i].
- `lock`  in  NUM_REQ  keep-grant hint. Used only when the configuration macro is defined.
- `ack`  out  NUM_REQ  one-cycle pulse; the byte from requester i has been captured.
- `tx_req`  out  1  one-cycle transmit request to the UART transmitter.
- `tx_byte`  out  8  byte for the transmitter; registered, stable from the ISSUE cycle until the next grant.
- `tx_busy`  in  1  transmitter busy flag.
- `owner`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `err_timeout`  out  1  one-cycle pulse; `tx_busy` never rose after a request.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE. Reset state is IDLE.
- **IDLE:**
  - If `tx_busy`=0 and any `req` bit is high, pick a winner.
  - Search order starts at `last+1` and wraps modulo NUM_REQ; the first high `req` wins.
  - Register `tx_byte` from the winner's `byte_in` and set `owner`=winner; go to ISSUE.
  - If `tx_busy`=1, stay in IDLE.
- **ISSUE** (exactly one cycle):
  - Drive `tx_req`=1 and `ack[owner]`=1; set `last`=`owner`.
  - Load the timeout counter with BUSY_TIMEOUT; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise decrement the counter. When it reaches 0, pulse `err_timeout` and go to IDLE. The byte is considered lost and is not retried.
- **WAIT_DONE:** when `tx_busy`=0, go to IDLE.
- `req` is sampled only in IDLE. Dropping `req` after the grant has no effect. Raising `req` mid-transfer is queued naturally.
- The `req` bit of the just-acked requester is not sampled in the cycle after `ack`. The requester must deassert or present its next byte by then.
- Reset mid-transfer:
  - All outputs return to reset values immediately; the state goes to IDLE.
  - The transmitter's in-flight byte completes on its own. The arbiter waits for `tx_busy`=0 before the next issue.
- Reset values:
  - `tx_req`, `ack`, `err_timeout` = 0.
  - `tx_byte` = 8'h00; `owner` = 0.
  - `last` = NUM_REQ-1, so requester 0 wins the first tie.

## Timing
- Latency: `req` high in cycle 0, with IDLE and `tx_busy`=0 → `tx_req` and `ack` both high in cycle 1.
- Minimum spacing between successive `tx_req` pulses is 4 cycles (ISSUE → WAIT_BUSY → WAIT_DONE → IDLE → ISSUE), plus the transmitter's busy time.
- `tx_busy` rising in the same cycle as ISSUE is seen in the following WAIT_BUSY cycle. No pulse is missed as long as `tx_busy` stays high for at least one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`UART_ARB_LOCK_EN` defined:**
  - In WAIT_DONE, if `lock[owner]` and `req[owner]` are both high when `tx_busy` falls, the next byte goes to the same owner. The block re-enters ISSUE directly from IDLE with no round-robin search.
  - This lets a requester send a multi-byte packet without interleaving.
  - `last` is still updated at every ISSUE.
- **Not defined:** the `lock` port is present but ignored; arbitration is pure per-byte round-robin.

## Test plan
- Single requester: `req[2]`=1, `byte_in`[23:16]=8'hA5, transmitter model busy for 20 cycles → one `tx_req` with `tx_byte`=8'hA5, `ack[2]` in the same cycle, `owner`=2.
- All four request continuously with bytes 8'h10..8'h13 → issue order 0,1,2,3,0,… and each `ack` is a single cycle.
- Timeout: transmitter model never raises `tx_busy` → `err_timeout` pulses 16 cycles after WAIT_BUSY is entered, then the next requester is served.
- Reset asserted during WAIT_DONE → outputs go to reset values at once. No `tx_req` until the model drops `tx_busy`; then requester 0 wins a full tie.
- With `UART_ARB_LOCK_EN`: `lock[1]`=`req[1]`=1 for 3 bytes while `req[0]`=1 → bytes from requester 1 go out three times in a row, then requester 0. Without the macro, requesters 0 and 1 alternate.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - Producer and transmitter signals of the shared UART TX arbiter.
// master is the arbiter's view; slave is the producers/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] byte_in;
  logic [NUM_REQ-1:0]   lock;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_req;
  logic [7:0]           tx_byte;
  logic                 tx_busy;
  logic [IDX_W-1:0]     owner;
  logic                 err_timeout;

  modport master (
    input  req,
    input  byte_in,
    input  lock,
    input  tx_busy,
    output ack,
    output tx_req,
    output tx_byte,
    output owner,
    output err_timeout
  );

  modport slave (
    output req,
    output byte_in,
    output lock,
    output tx_busy,
    input  ack,
    input  tx_req,
    input  tx_byte,
    input  owner,
    input  err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - Byte-wise round-robin arbiter sharing one UART transmitter.
// Define UART_ARB_LOCK_EN to let a requester holding lock[owner] keep the grant across bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_found;
  logic [IDX_W-1:0] winner;
  logic             grant;

`ifdef UART_ARB_LOCK_EN
  logic lock_hold;
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  // First high req scanning from last+1, wrapping modulo NUM_REQ.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last;
    cand      = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!rr_found && bus.req[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_comb begin
    winner = rr_winner;
    grant  = rr_found;
`ifdef UART_ARB_LOCK_EN
    if (lock_hold && bus.req[bus.owner]) begin
      winner = bus.owner;
      grant  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last            <= IDX_W'(NUM_REQ - 1);
      cnt             <= 8'h00;
      bus.tx_req      <= 1'b0;
      bus.ack         <= '0;
      bus.tx_byte     <= 8'h00;
      bus.owner       <= '0;
      bus.err_timeout <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_hold       <= 1'b0;
`endif
    end else begin
      bus.tx_req      <= 1'b0;
      bus.ack         <= '0;
      bus.err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.tx_busy && grant) begin
            bus.tx_byte <= bus.byte_in[{winner, 3'b000} +: 8];
            bus.owner   <= winner;
            bus.tx_req  <= 1'b1;
            bus.ack     <= NUM_REQ'(1) << winner;
`ifdef UART_ARB_LOCK_EN
            lock_hold   <= 1'b0;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          last  <= bus.owner;
          cnt   <= 8'(BUSY_TIMEOUT);
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt <= 8'd1) begin
            // The byte is dropped; the transmitter never acknowledged it.
            cnt             <= 8'h00;
            bus.err_timeout <= 1'b1;
            state           <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
`ifdef UART_ARB_LOCK_EN
            lock_hold <= bus.lock[bus.owner] && bus.req[bus.owner];
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - Scoreboard bench for uart_tx_arbiter with a busy-flag transmitter model.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int BW           = 8 * NUM_REQ;

  typedef struct {
    int         owner;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] rq[NUM_REQ][$];
  int checks         = 0;
  int errors         = 0;
  int cyc            = 0;
  int last_issue_cyc = 0;
  int timeouts_seen  = 0;
  int busy_cnt       = 0;
  int busy_len       = 4;
  int add_cyc        = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    logic [BW-1:0] mask;
    mask        = BW'(8'hFF) << (8 * i);
    bus.byte_in = (bus.byte_in & ~mask) | (BW'(b) << (8 * i));
  endtask

  task automatic set_req(input int i, input logic v);
    if (v) bus.req = bus.req | (NUM_REQ'(1) << i);
    else   bus.req = bus.req & ~(NUM_REQ'(1) << i);
  endtask

  task automatic add_byte(input int i, input logic [7:0] b);
    rq[i].push_back(b);
    set_byte(i, rq[i][0]);
    set_req(i, 1'b1);
  endtask

  task automatic expect_issue(input int o, input logic [7:0] b);
    exp_t e;
    e.owner = o;
    e.data  = b;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_req"}, 32'(bus.tx_req), 0);
    check({tag, "_ack"}, 32'(bus.ack), 0);
    check({tag, "_tx_byte"}, 32'(bus.tx_byte), 0);
    check({tag, "_owner"}, 32'(bus.owner), 0);
    check({tag, "_err_timeout"}, 32'(bus.err_timeout), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy_cnt != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 0);
    repeat (25) @(posedge clk);
    #2;
  endtask

  // Monitor, requester model and transmitter model, all evaluated mid-cycle.
  initial forever begin
    exp_t e;
    logic [NUM_REQ-1:0] ack_bits;
    @(negedge clk);
    cyc++;
    if (bus.tx_req) begin
      check("issue_while_busy", 32'(bus.tx_busy), 0);
      last_issue_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("owner", 32'(bus.owner), 32'(e.owner));
        check("tx_byte", 32'(bus.tx_byte), 32'(e.data));
        check("ack", 32'(bus.ack), 32'(NUM_REQ'(1) << e.owner));
      end
    end else begin
      check("ack_without_req", 32'(bus.ack), 0);
    end
    if (bus.err_timeout) begin
      timeouts_seen++;
      check("timeout_gap", 32'(cyc - last_issue_cyc), 32'(BUSY_TIMEOUT + 1));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_bits = bus.ack >> i;
      if (ack_bits[0] && rq[i].size() > 0) begin
        void'(rq[i].pop_front());
        if (rq[i].size() > 0) set_byte(i, rq[i][0]);
        else                  set_req(i, 1'b0);
      end
    end
    if (busy_cnt > 0) busy_cnt--;
    if (bus.tx_req && busy_len > 0) busy_cnt = busy_len;
    bus.tx_busy = (busy_cnt > 0);
  end

  initial begin
    int n;
    bus.req     = '0;
    bus.byte_in = '0;
    bus.lock    = '0;
    bus.tx_busy = 1'b0;

    do_reset();

    // Single requester, long busy.
    busy_len = 20;
    @(posedge clk); #2;
    add_byte(2, 8'hA5);
    expect_issue(2, 8'hA5);
    add_cyc = cyc;
    wait_drain("drain_single");
    check("latency", 32'(last_issue_cyc - add_cyc), 2);

    // All four requesting, two bytes each, starting from a fresh tie.
    do_reset();
    busy_len = 3;
    for (int i = 0; i < NUM_REQ; i++) begin
      add_byte(i, 8'(8'h10 + i));
      add_byte(i, 8'(8'h20 + i));
    end
    for (int i = 0; i < NUM_REQ; i++) expect_issue(i, 8'(8'h10 + i));
    for (int i = 0; i < NUM_REQ; i++) expect_issue(i, 8'(8'h20 + i));
    wait_drain("drain_rr");
    check("no_early_timeout", 32'(timeouts_seen), 0);

    // Transmitter never goes busy: both bytes time out and are not retried.
    busy_len = 0;
    @(posedge clk); #2;
    add_byte(1, 8'h31);
    add_byte(2, 8'h32);
    expect_issue(1, 8'h31);
    expect_issue(2, 8'h32);
    wait_drain("drain_timeout");
    check("timeouts", 32'(timeouts_seen), 2);

    // Reset while the transmitter is busy with an in-flight byte.
    busy_len = 40;
    @(posedge clk); #2;
    add_byte(3, 8'h77);
    expect_issue(3, 8'h77);
    n = 0;
    while (!bus.tx_busy && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("busy_rose", 32'(bus.tx_busy), 1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    for (int i = 0; i < NUM_REQ; i++) begin
      add_byte(i, 8'(8'h40 + i));
      expect_issue(i, 8'(8'h40 + i));
    end
    @(posedge clk); #2;
    rst = 1'b0;
    busy_len = 4;
    wait_drain("drain_mid_reset");

    // Multi-byte burst from requester 1 with lock held, requester 0 competing.
    do_reset();
    busy_len = 4;
    bus.lock = NUM_REQ'(2);
    add_byte(1, 8'h51);
    add_byte(1, 8'h52);
    add_byte(1, 8'h53);
    expect_issue(1, 8'h51);
    @(posedge clk); #2;
    add_byte(0, 8'h50);
`ifdef UART_ARB_LOCK_EN
    expect_issue(1, 8'h52);
    expect_issue(1, 8'h53);
    expect_issue(0, 8'h50);
`else
    expect_issue(0, 8'h50);
    expect_issue(1, 8'h52);
    expect_issue(1, 8'h53);
`endif
    wait_drain("drain_lock");
    bus.lock = '0;

    check("timeouts_total", 32'(timeouts_seen), 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
